// File: rtl/sram_burst_controller.sv
// sram_burst_controller
//   Avalon-MM slave that drives an external asynchronous SRAM with
//   configurable data/address width, burst reads and writes, programmable
//   read/write wait states and a read-to-idle bus turnaround.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   SRAM_DQ         bidirectional data bus, driven only while writing
//   SRAM_ADDR       word address (registered)
//   SRAM_BE_N       byte lane enables, active low (bit0 = LB_N, bit1 = UB_N)
//   SRAM_CE_N/OE_N/WE_N  chip/output/write enables, active low (registered)
//   address         first-beat word address
//   byteenable      per-write-beat byte enables
//   read, write     command strobes; write is also the per-beat strobe
//   writedata       write beat data
//   burstcount      beats in burst (0 -> 1, values above MAX_BURST clamp)
//   waitrequest     combinational stall, low only in IDLE and WR_NEXT
//   readdata        read beat data
//   readdatavalid   one-cycle pulse per read beat
module sram_burst_controller #(
  parameter  int DATA_W    = 16,
  parameter  int ADDR_W    = 20,
  parameter  int RD_WAIT   = 1,
  parameter  int WR_WAIT   = 1,
  parameter  int TURN      = 1,
  parameter  int MAX_BURST = 16,
  localparam int BURST_W   = $clog2(MAX_BURST) + 1,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic               clk,
  input  logic               reset,
  inout  wire  [DATA_W-1:0]  SRAM_DQ,
  output logic [ADDR_W-1:0]  SRAM_ADDR,
  output logic [BE_W-1:0]    SRAM_BE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  input  logic [ADDR_W-1:0]  address,
  input  logic [BE_W-1:0]    byteenable,
  input  logic               read,
  input  logic               write,
  input  logic [DATA_W-1:0]  writedata,
  input  logic [BURST_W-1:0] burstcount,
  output logic               waitrequest,
  output logic [DATA_W-1:0]  readdata,
  output logic               readdatavalid
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                                                : ((WR_WAIT > TURN) ? WR_WAIT : TURN);
  localparam int CNT_W    = $clog2(MAX_WAIT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_TURN,
    S_WR,
    S_WR_REC,
    S_WR_NEXT
  } state_t;

  state_t             state, nxt_state;
  logic [BURST_W-1:0] beats, nxt_beats;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [DATA_W-1:0]  dq_out, nxt_dq_out;
  logic               dq_oe, nxt_dq_oe;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [BE_W-1:0]    nxt_be_n;
  logic               nxt_ce_n, nxt_oe_n, nxt_we_n;
  logic [DATA_W-1:0]  nxt_readdata;
  logic               nxt_readdatavalid;
  logic [BURST_W-1:0] beats_req;

  assign SRAM_DQ     = dq_oe ? dq_out : {DATA_W{1'bz}};
  assign waitrequest = reset | !(state == S_IDLE || state == S_WR_NEXT);

  // Burst length as the controller will execute it.
  always_comb begin
    if (burstcount == '0)
      beats_req = BURST_W'(1);
    else if (burstcount > BURST_W'(MAX_BURST))
      beats_req = BURST_W'(MAX_BURST);
    else
      beats_req = burstcount;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      beats         <= '0;
      cnt           <= '0;
      dq_out        <= '0;
      dq_oe         <= 1'b0;
      SRAM_ADDR     <= '0;
      SRAM_BE_N     <= '1;
      SRAM_CE_N     <= 1'b1;
      SRAM_OE_N     <= 1'b1;
      SRAM_WE_N     <= 1'b1;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      state         <= nxt_state;
      beats         <= nxt_beats;
      cnt           <= nxt_cnt;
      dq_out        <= nxt_dq_out;
      dq_oe         <= nxt_dq_oe;
      SRAM_ADDR     <= nxt_addr;
      SRAM_BE_N     <= nxt_be_n;
      SRAM_CE_N     <= nxt_ce_n;
      SRAM_OE_N     <= nxt_oe_n;
      SRAM_WE_N     <= nxt_we_n;
      readdata      <= nxt_readdata;
      readdatavalid <= nxt_readdatavalid;
    end
  end

  always_comb begin
    nxt_state         = state;
    nxt_beats         = beats;
    nxt_cnt           = cnt;
    nxt_dq_out        = dq_out;
    nxt_dq_oe         = dq_oe;
    nxt_addr          = SRAM_ADDR;
    nxt_be_n          = SRAM_BE_N;
    nxt_ce_n          = SRAM_CE_N;
    nxt_oe_n          = SRAM_OE_N;
    nxt_we_n          = SRAM_WE_N;
    nxt_readdata      = readdata;
    nxt_readdatavalid = 1'b0;

    case (state)
      S_IDLE: begin
        // read has priority; a simultaneous write is simply not accepted
        if (read) begin
          nxt_state = S_RD;
          nxt_addr  = address;
          nxt_beats = beats_req;
          nxt_cnt   = CNT_W'(RD_WAIT);
          nxt_ce_n  = 1'b0;
          nxt_oe_n  = 1'b0;
          nxt_we_n  = 1'b1;
          nxt_be_n  = '0;
          nxt_dq_oe = 1'b0;
        end else if (write) begin
          nxt_state  = S_WR;
          nxt_addr   = address;
          nxt_beats  = beats_req;
          nxt_cnt    = CNT_W'(WR_WAIT);
          nxt_dq_out = writedata;
          nxt_dq_oe  = 1'b1;
          nxt_be_n   = ~byteenable;
          nxt_ce_n   = 1'b0;
          nxt_oe_n   = 1'b1;
          nxt_we_n   = 1'b0;
        end
      end

      S_RD: begin
        if (cnt == '0) begin
          nxt_readdata      = SRAM_DQ;
          nxt_readdatavalid = 1'b1;
          if (beats == BURST_W'(1)) begin
            // Release the bus right away; the valid cycle overlaps the first
            // turnaround cycle, and TURN further idle cycles follow it.
            nxt_state = S_TURN;
            nxt_cnt   = CNT_W'(TURN);
            nxt_oe_n  = 1'b1;
            nxt_ce_n  = 1'b1;
            nxt_be_n  = '1;
          end else begin
            nxt_beats = beats - BURST_W'(1);
            nxt_addr  = SRAM_ADDR + ADDR_W'(1);
            nxt_cnt   = CNT_W'(RD_WAIT);
          end
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end

      S_TURN: begin
        if (cnt == '0)
          nxt_state = S_IDLE;
        else
          nxt_cnt = cnt - CNT_W'(1);
      end

      S_WR: begin
        if (cnt == '0) begin
          nxt_state = S_WR_REC;
          nxt_we_n  = 1'b1;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end

      // WE_N is already high; address, data and lanes stay put for hold time.
      S_WR_REC: begin
        if (beats == BURST_W'(1)) begin
          nxt_state = S_IDLE;
          nxt_ce_n  = 1'b1;
          nxt_be_n  = '1;
          nxt_dq_oe = 1'b0;
        end else begin
          nxt_state = S_WR_NEXT;
          nxt_beats = beats - BURST_W'(1);
        end
      end

      // Waiting for the master's next beat; read is ignored here.
      S_WR_NEXT: begin
        if (write) begin
          nxt_state  = S_WR;
          nxt_addr   = SRAM_ADDR + ADDR_W'(1);
          nxt_cnt    = CNT_W'(WR_WAIT);
          nxt_dq_out = writedata;
          nxt_be_n   = ~byteenable;
          nxt_we_n   = 1'b0;
        end
      end

      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_burst_controller.sv
// tb_sram_burst_controller
//   Randomized scoreboard bench: stimulus pushes expected read beats and
//   write pulses into queues (from a sparse reference memory); independent
//   monitors pop and compare whenever readdatavalid pulses or WE_N pulses.
//   An asynchronous SRAM model sits on the pins.
module tb_sram_burst_controller;
  localparam int DW = 16, AW = 20, RDW = 1, WRW = 1, TRN = 1, MB = 16;
  localparam int BW = $clog2(MB) + 1;

  logic          clk = 1'b0, reset = 1'b0;
  wire  [DW-1:0] SRAM_DQ;
  logic [AW-1:0] SRAM_ADDR;
  logic [1:0]    SRAM_BE_N;
  logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic [AW-1:0] address = '0;
  logic [1:0]    byteenable = '0;
  logic          read = 1'b0, write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic [BW-1:0] burstcount = '0;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  sram_burst_controller #(.DATA_W(DW), .ADDR_W(AW), .RD_WAIT(RDW), .WR_WAIT(WRW),
                          .TURN(TRN), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_BE_N(SRAM_BE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata), .burstcount(burstcount),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  bit started = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM pin model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : {DW{1'bz}};

  // Reference memory
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction
  task automatic ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    logic [DW-1:0] o;
    o = ref_rd(a);
    ref_mem[int'(a)] = {be[1] ? d[15:8] : o[15:8], be[0] ? d[7:0] : o[7:0]};
  endtask
  function automatic int clampb(input int bc);
    return (bc == 0) ? 1 : ((bc > MB) ? MB : bc);
  endfunction

  typedef struct { logic [DW-1:0] d; int at; } rd_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [1:0] ben; } wr_t;
  rd_t exp_rd [$];
  wr_t exp_wr [$];

  // Read monitor: readdatavalid seen by the master at edge cyc+1
  always @(negedge clk) begin
    rd_t e;
    if (started && !reset) begin
      if (!SRAM_OE_N && !SRAM_WE_N) chk(0, "oe_we_overlap", 1, 0);
      if (readdatavalid) begin
        if (exp_rd.size() == 0) chk(0, "spurious_readdatavalid", readdata, 0);
        else begin
          e = exp_rd.pop_front();
          chk(readdata === e.d, "rd_data", readdata, e.d);
          chk(cyc + 1 == e.at, "rd_edge", cyc + 1, e.at);
        end
      end
    end
  end

  // Write monitor: checks each WE_N pulse, its hold cycle, and updates the SRAM
  int we_len = 0;
  logic [AW-1:0] cap_a;
  logic [DW-1:0] cap_d;
  logic [1:0]    cap_b;
  always @(negedge clk) begin
    wr_t e;
    if (started && !reset) begin
      if (!SRAM_WE_N) begin
        if (we_len == 0) begin
          cap_a = SRAM_ADDR; cap_d = SRAM_DQ; cap_b = SRAM_BE_N;
          if (exp_wr.size() == 0) chk(0, "spurious_write", cap_a, 0);
          else begin
            e = exp_wr.pop_front();
            chk(cap_a === e.a, "wr_addr", cap_a, e.a);
            chk(cap_d === e.d, "wr_data", cap_d, e.d);
            chk(cap_b === e.ben, "wr_be_n", cap_b, e.ben);
          end
        end else begin
          chk(SRAM_ADDR === cap_a && SRAM_DQ === cap_d, "wr_stable", SRAM_DQ, cap_d);
        end
        we_len++;
      end else if (we_len != 0) begin
        chk(we_len == WRW + 1, "we_pulse_len", we_len, WRW + 1);
        chk(SRAM_ADDR === cap_a && SRAM_DQ === cap_d && SRAM_BE_N === cap_b && !SRAM_CE_N,
            "wr_hold", SRAM_DQ, cap_d);
        if (!cap_b[0]) mem[cap_a][7:0]  = cap_d[7:0];
        if (!cap_b[1]) mem[cap_a][15:8] = cap_d[15:8];
        we_len = 0;
      end
    end
  end

  // Called at a negedge; returns the edge at which the command is accepted.
  task automatic wait_ready(output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 500; i++) begin
      if (!waitrequest) begin at = cyc + 1; ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk(0, "timeout_waitrequest", 1, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int bc, input bit both);
    int n, at, rt; bit ok; rd_t e;
    n = clampb(bc);
    address = a; burstcount = BW'(bc); read = 1'b1;
    write = both; writedata = 16'($urandom); byteenable = 2'b11;
    wait_ready(at, ok);
    if (!ok) begin read = 0; write = 0; return; end
    for (int k = 0; k < n; k++) begin
      e.d  = ref_rd(a + AW'(k));
      e.at = at + RDW + 2 + k * (RDW + 1);
      exp_rd.push_back(e);
    end
    @(posedge clk); @(negedge clk);
    read = 1'b0; write = 1'b0;
    wait_ready(rt, ok);
    if (ok) chk(rt == at + n * (RDW + 1) + TRN + 2, "rd_occupancy", rt - at, n * (RDW + 1) + TRN + 2);
  endtask

  logic [DW-1:0] wd [MB];
  logic [1:0]    wb [MB];
  int            st [MB];

  task automatic do_write(input logic [AW-1:0] a, input int bc);
    int n, at, rt; bit ok; wr_t e; logic [AW-1:0] ba;
    n = clampb(bc); at = 0;
    address = a; burstcount = BW'(bc);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        wait_ready(rt, ok);
        if (!ok) return;
        for (int s = 0; s < st[k]; s++) begin
          @(negedge clk);
          chk(!waitrequest && SRAM_WE_N && !SRAM_CE_N, "wr_next_stall",
              {waitrequest, SRAM_WE_N, SRAM_CE_N}, 3'b010);
        end
      end
      ba = a + AW'(k);
      write = 1'b1; writedata = wd[k]; byteenable = wb[k];
      e.a = ba; e.d = wd[k]; e.ben = ~wb[k];
      exp_wr.push_back(e);
      ref_wr(ba, wd[k], wb[k]);
      wait_ready(at, ok);
      if (!ok) begin write = 1'b0; return; end
      @(posedge clk); @(negedge clk);
      write = 1'b0;
    end
    wait_ready(rt, ok);
    if (ok) chk(rt == at + WRW + 3, "wr_occupancy", rt - at, WRW + 3);
  endtask

  task automatic check_reset(input string tag);
    chk(SRAM_CE_N && SRAM_OE_N && SRAM_WE_N, {tag, "_ctl"}, {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
    chk(SRAM_BE_N == 2'b11, {tag, "_be_n"}, SRAM_BE_N, 2'b11);
    chk(SRAM_ADDR == '0, {tag, "_addr"}, SRAM_ADDR, 0);
    chk(readdata == '0, {tag, "_readdata"}, readdata, 0);
    chk(!readdatavalid, {tag, "_rdv"}, readdatavalid, 0);
    chk(waitrequest, {tag, "_waitrequest"}, waitrequest, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int at; bit ok;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 1'b0; started = 1'b1;
    @(negedge clk);

    // single write, then a 4-beat write and burst read back
    wd[0] = 16'hBEEF; wb[0] = 2'b11;
    do_write(20'h00010, 1);
    for (int k = 0; k < 4; k++) begin wd[k] = 16'h1111 * 16'(k + 1); wb[k] = 2'b11; st[k] = 0; end
    do_write(20'h00010, 4);
    do_read(20'h00010, 4, 1'b0);

    // partial byte write over 0xFFFF
    wd[0] = 16'hFFFF; wb[0] = 2'b11; do_write(20'h00030, 1);
    wd[0] = 16'hAB12; wb[0] = 2'b01; do_write(20'h00030, 1);
    chk(ref_rd(20'h00030) == 16'hFF12, "ref_partial", ref_rd(20'h00030), 16'hFF12);
    do_read(20'h00030, 1, 1'b0);

    // wrapping burst with a 5-cycle master stall before beat 2
    for (int k = 0; k < 3; k++) begin wd[k] = 16'hC000 + 16'(k); wb[k] = 2'b11; st[k] = 0; end
    st[1] = 5;
    do_write(20'hFFFFF, 3);
    do_read(20'hFFFFF, 3, 1'b0);

    // read and write together: only the read runs
    do_read(20'h00020, 1, 1'b1);
    do_read(20'h00020, 2, 1'b0);

    // burstcount boundaries
    wd[0] = 16'h5A5A; wb[0] = 2'b10; do_write(20'h00040, 0);
    do_read(20'h00040, 0, 1'b0);
    for (int k = 0; k < MB; k++) begin wd[k] = 16'($urandom); wb[k] = 2'b11; st[k] = k % 2; end
    do_write(20'h00100, 31);
    do_read(20'h00100, 31, 1'b0);

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      logic [AW-1:0] a; int bc;
      a = ($urandom_range(0, 3) == 0) ? 20'hFFFF8 + AW'($urandom_range(0, 7))
                                      : AW'($urandom_range(0, 63));
      bc = $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < MB; k++) begin
          wd[k] = 16'($urandom); wb[k] = 2'($urandom_range(0, 3)); st[k] = $urandom_range(0, 3);
        end
        do_write(a, bc);
      end else begin
        do_read(a, bc, $urandom_range(0, 3) == 0);
      end
    end

    // reset at E4 of a 4-beat read
    address = 20'h00010; burstcount = BW'(4); read = 1'b1; write = 1'b0;
    wait_ready(at, ok);
    if (ok) begin
      rd_t e;
      e.d = ref_rd(20'h00010); e.at = at + RDW + 2;
      exp_rd.push_back(e);
      @(posedge clk); @(negedge clk);
      read = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      chk(exp_rd.size() == 0, "beat0_before_reset", exp_rd.size(), 0);
      exp_rd.delete();
      #1 check_reset("midburst_reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
    end
    read = 1'b0;
    do_read(20'h00011, 2, 1'b0);

    for (int i = 0; i < 100 && exp_rd.size() != 0; i++) @(negedge clk);
    chk(exp_rd.size() == 0, "missing_readdatavalid", exp_rd.size(), 0);
    chk(exp_wr.size() == 0, "missing_write", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
